// File: rtl/cache_mem_arbiter.sv
// Two-cache to single-pmem arbiter: grants one 256-bit line request at a time and runs it as a 4-beat burst.
// Optional: define ARB_ROUND_ROBIN_EN to alternate between the caches when both request together.
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_mem_read,
   input  logic [ADDR_WIDTH-1:0] icache_mem_address,
   output logic [LINE_WIDTH-1:0] icache_mem_rdata,
   output logic                  icache_mem_resp,
   input  logic                  dcache_mem_read,
   input  logic                  dcache_mem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_mem_address,
   input  logic [LINE_WIDTH-1:0] dcache_mem_wdata,
   output logic [LINE_WIDTH-1:0] dcache_mem_rdata,
   output logic                  dcache_mem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [BEAT_WIDTH-1:0] pmem_wdata,
   input  logic [BEAT_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);
   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((LINE_WIDTH / 8) - 1);

   typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_e;

   function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
      return a & ~OFF_MASK;
   endfunction

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;
   logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] irdata_q, irdata_d;
   logic [LINE_WIDTH-1:0] drdata_q, drdata_d;
   logic                  iresp_q, iresp_d;
   logic                  dresp_q, dresp_d;
   logic                  pread_q, pread_d;
   logic                  pwrite_q, pwrite_d;
   logic [BEAT_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  grant_i;
`ifdef ARB_ROUND_ROBIN_EN
   logic                  last_d_q, last_d_d;
`endif

   // I-cache wins only when the D side is quiet, or (round-robin) when D was served last.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_i = icache_mem_read && (!(dcache_mem_read || dcache_mem_write) || last_d_q);
`else
      grant_i = icache_mem_read && !(dcache_mem_read || dcache_mem_write);
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      wbuf_d   = wbuf_q;
      addr_d   = addr_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      iresp_d  = 1'b0;
      dresp_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (grant_i) begin
               state_d = I_READ;
               addr_d  = line_align(icache_mem_address);
            end else if (dcache_mem_write) begin
               state_d = D_WRITE;
               addr_d  = line_align(dcache_mem_address);
               wbuf_d  = dcache_mem_wdata;
            end else if (dcache_mem_read) begin
               state_d = D_READ;
               addr_d  = line_align(dcache_mem_address);
            end
         end
         I_READ, D_READ, D_WRITE: begin
            if (pmem_resp) begin
               if (state_q != D_WRITE)
                  line_d[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = pmem_rdata;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
                  if (state_q == I_READ) begin
                     irdata_d = line_d;
                     iresp_d  = 1'b1;
                  end else begin
                     if (state_q == D_READ)
                        drdata_d = line_d;
                     dresp_d = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_d = dresp_q;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Strobes and write beat are registered so they line up with the state they belong to.
      pread_d  = (state_d == I_READ) || (state_d == D_READ);
      pwrite_d = (state_d == D_WRITE);
      pwdata_d = pwrite_d ? wbuf_d[int'(cnt_d) * BEAT_WIDTH +: BEAT_WIDTH] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         line_q   <= '0;
         wbuf_q   <= '0;
         addr_q   <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
         iresp_q  <= 1'b0;
         dresp_q  <= 1'b0;
         pread_q  <= 1'b0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         line_q   <= line_d;
         wbuf_q   <= wbuf_d;
         addr_q   <= addr_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         iresp_q  <= iresp_d;
         dresp_q  <= dresp_d;
         pread_q  <= pread_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= last_d_d;
`endif
      end
   end

   assign icache_mem_rdata = irdata_q;
   assign icache_mem_resp  = iresp_q;
   assign dcache_mem_rdata = drdata_q;
   assign dcache_mem_resp  = dresp_q;
   assign pmem_read        = pread_q;
   assign pmem_write       = pwrite_q;
   assign pmem_address     = addr_q;
   assign pmem_wdata       = pwdata_q;

`ifndef SYNTHESIS
   // The D-cache must never ask for a read and a writeback at once.
   dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(dcache_mem_read && dcache_mem_write));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized transactions against a line-level model.
module tb_cache_mem_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         icache_mem_read;
   logic [31:0]  icache_mem_address;
   logic [255:0] icache_mem_rdata;
   logic         icache_mem_resp;
   logic         dcache_mem_read;
   logic         dcache_mem_write;
   logic [31:0]  dcache_mem_address;
   logic [255:0] dcache_mem_wdata;
   logic [255:0] dcache_mem_rdata;
   logic         dcache_mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [63:0]  pmem_wdata;
   logic [63:0]  pmem_rdata;
   logic         pmem_resp;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   cache_mem_arbiter dut (
      .clk                (clk),
      .rst                (rst),
      .icache_mem_read    (icache_mem_read),
      .icache_mem_address (icache_mem_address),
      .icache_mem_rdata   (icache_mem_rdata),
      .icache_mem_resp    (icache_mem_resp),
      .dcache_mem_read    (dcache_mem_read),
      .dcache_mem_write   (dcache_mem_write),
      .dcache_mem_address (dcache_mem_address),
      .dcache_mem_wdata   (dcache_mem_wdata),
      .dcache_mem_rdata   (dcache_mem_rdata),
      .dcache_mem_resp    (dcache_mem_resp),
      .pmem_read          (pmem_read),
      .pmem_write         (pmem_write),
      .pmem_address       (pmem_address),
      .pmem_wdata         (pmem_wdata),
      .pmem_rdata         (pmem_rdata),
      .pmem_resp          (pmem_resp)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Physical memory model: one beat every (pm_wait+1) strobe cycles.
   logic [63:0] rd_arr [0:2047];
   logic [63:0] wr_arr [0:2047];
   int pm_rd_n = 0;
   int pm_wr_n = 0;
   int pm_gap  = 0;
   int pm_wait = 0;
   bit stray   = 1'b0;

   always @(posedge clk) begin
      #1;
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
         if (pm_gap >= pm_wait) begin
            pm_gap    = 0;
            pmem_resp = 1'b1;
            if (pmem_read) begin
               pmem_rdata = rd_arr[pm_rd_n];
               pm_rd_n++;
            end else begin
               wr_arr[pm_wr_n] = pmem_wdata;
               pm_wr_n++;
            end
         end else begin
            pm_gap++;
         end
      end else begin
         pm_gap = 0;
         if (stray) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
         end
      end
   end

   // Output monitor
   int i_pulses = 0, d_pulses = 0, both_hi = 0, strobe_in_done = 0;
   int rd_cycles = 0, wr_cycles = 0, addr_moves = 0;
   logic [255:0] last_i_line = '0, last_d_line = '0;
   int order_arr [0:511];
   int n_order = 0;
   logic [31:0] addr_arr [0:511];
   int n_addr = 0;
   bit prev_strobe = 1'b0;
   logic [31:0] prev_addr = '0;

   always @(negedge clk) begin
      if (icache_mem_resp) begin
         i_pulses++;
         last_i_line = icache_mem_rdata;
         order_arr[n_order] = 0;
         n_order++;
      end
      if (dcache_mem_resp) begin
         d_pulses++;
         last_d_line = dcache_mem_rdata;
         order_arr[n_order] = 1;
         n_order++;
      end
      if (icache_mem_resp && dcache_mem_resp) both_hi++;
      if ((icache_mem_resp || dcache_mem_resp) && (pmem_read || pmem_write)) strobe_in_done++;
      if (pmem_read) rd_cycles++;
      if (pmem_write) wr_cycles++;
      if ((pmem_read || pmem_write) && !prev_strobe) begin
         addr_arr[n_addr] = pmem_address;
         n_addr++;
      end else if ((pmem_read || pmem_write) && pmem_address != prev_addr) begin
         addr_moves++;
      end
      prev_strobe = pmem_read || pmem_write;
      prev_addr   = pmem_address;
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checki(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic [63:0] bt [0:7];
   int rd_base, wr_base, i0, d0, ord0, rc0, wc0, a0;
   bit last_d = 1'b1;

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [255:0] line_of(input int s);
      return {bt[s+3], bt[s+2], bt[s+1], bt[s]};
   endfunction

   task automatic load(input int n);
      for (int k = 0; k < n; k++) rd_arr[pm_rd_n + k] = bt[k];
   endtask

   task automatic snap();
      rd_base = pm_rd_n; wr_base = pm_wr_n; i0 = i_pulses; d0 = d_pulses;
      ord0 = n_order; rc0 = rd_cycles; wc0 = wr_cycles; a0 = n_addr;
   endtask

   // Requesters hold their request until their resp, then drop it before the next edge.
   task automatic serve(input int budget);
      int n;
      n = 0;
      while ((icache_mem_read || dcache_mem_read || dcache_mem_write) && n < budget) begin
         @(negedge clk);
         n++;
         if (icache_mem_resp) icache_mem_read = 1'b0;
         if (dcache_mem_resp) begin
            dcache_mem_read  = 1'b0;
            dcache_mem_write = 1'b0;
         end
      end
      checki("serve_timeout", int'(icache_mem_read || dcache_mem_read || dcache_mem_write), 0);
      icache_mem_read = 1'b0; dcache_mem_read = 1'b0; dcache_mem_write = 1'b0;
      @(posedge clk); #2;
   endtask

   initial begin
      bit first_d;
      int kind, n;
      logic [31:0] ia, da;
      logic [255:0] wl, saved_i;
      rst = 1'b1;
      icache_mem_read = 1'b0; icache_mem_address = '0;
      dcache_mem_read = 1'b0; dcache_mem_write = 1'b0;
      dcache_mem_address = '0; dcache_mem_wdata = '0;
      repeat (3) @(negedge clk);
      checki("rst_strobes", int'({pmem_read, pmem_write}), 0);
      checki("rst_resps", int'({icache_mem_resp, dcache_mem_resp}), 0);
      check("rst_addr_wdata", {192'b0, pmem_address, pmem_wdata}, '0);
      check("rst_irdata", icache_mem_rdata, '0);
      check("rst_drdata", dcache_mem_rdata, '0);
      rst = 1'b0;
      @(posedge clk); #2;

      // I-cache read, zero-wait pmem
      bt[0] = {16{4'h1}}; bt[1] = {16{4'h2}}; bt[2] = {16{4'h3}}; bt[3] = {16{4'h4}};
      load(4); snap(); pm_wait = 0;
      icache_mem_address = 32'h0000_0060; icache_mem_read = 1'b1;
      serve(40);
      checki("t1_rd_cycles", rd_cycles - rc0, 4);
      checki("t1_addr", int'(addr_arr[n_addr-1]), 32'h0000_0060);
      checki("t1_i_pulses", i_pulses - i0, 1);
      checki("t1_d_pulses", d_pulses - d0, 0);
      check("t1_line", last_i_line, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
      saved_i = last_i_line;
      last_d = 1'b0;

      // D-cache writeback, pmem answers every second cycle
      bt[0] = {16{4'hA}}; bt[1] = {16{4'hB}}; bt[2] = {16{4'hC}}; bt[3] = {16{4'hD}};
      snap(); pm_wait = 1;
      dcache_mem_address = 32'h8000_0020; dcache_mem_wdata = line_of(0); dcache_mem_write = 1'b1;
      serve(60);
      for (int k = 0; k < 4; k++) check($sformatf("t2_wbeat%0d", k), {192'b0, wr_arr[wr_base + k]}, {192'b0, bt[k]});
      checki("t2_wr_cycles", wr_cycles - wc0, 8);
      checki("t2_addr", int'(addr_arr[n_addr-1]), 32'h8000_0020);
      checki("t2_d_pulses", d_pulses - d0, 1);
      checki("t2_i_pulses", i_pulses - i0, 0);
      check("t2_irdata_held", icache_mem_rdata, saved_i);
      last_d = 1'b1;

      // Both caches read together, twice in a row
      pm_wait = 0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 8; k++) bt[k] = rnd64();
         load(8); snap();
         icache_mem_address = 32'h0000_1000 + 32'(r * 64); icache_mem_read = 1'b1;
         dcache_mem_address = 32'h0000_2000 + 32'(r * 64); dcache_mem_read = 1'b1;
         serve(80);
         first_d = RR ? !last_d : 1'b1;
         checki($sformatf("pair%0d_first", r), order_arr[ord0], int'(first_d));
         checki($sformatf("pair%0d_second", r), order_arr[ord0 + 1], int'(!first_d));
         check($sformatf("pair%0d_iline", r), last_i_line, first_d ? line_of(4) : line_of(0));
         check($sformatf("pair%0d_dline", r), last_d_line, first_d ? line_of(0) : line_of(4));
         last_d = !first_d;
      end
      checki("pair_both_hi", both_hi, 0);

      // Unaligned address is line-aligned on pmem
      for (int k = 0; k < 4; k++) bt[k] = rnd64();
      load(4); snap();
      icache_mem_address = 32'h1234_567F; icache_mem_read = 1'b1;
      serve(40);
      checki("unal_addr", int'(addr_arr[n_addr-1]), 32'h1234_5660);
      check("unal_line", last_i_line, line_of(0));
      last_d = 1'b0;

      // Reset in the middle of an I-read, then the held request completes
      for (int k = 0; k < 4; k++) bt[k] = rnd64();
      load(4); snap();
      icache_mem_address = 32'h0000_0400; icache_mem_read = 1'b1;
      n = 0;
      while (pm_rd_n < rd_base + 2 && n < 50) begin @(negedge clk); n++; end
      checki("rstm_started", int'(pm_rd_n >= rd_base + 2), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checki("rstm_pmem_read", int'(pmem_read), 0);
      repeat (2) @(negedge clk);
      checki("rstm_no_resp", i_pulses - i0, 0);
      for (int k = 0; k < 4; k++) bt[k] = rnd64();
      load(4);
      last_d = 1'b1;
      rst = 1'b0;
      serve(40);
      checki("rstm_one_resp", i_pulses - i0, 1);
      check("rstm_fresh_line", last_i_line, line_of(0));
      last_d = 1'b0;

      // Stray pmem_resp while idle
      snap();
      stray = 1'b1;
      repeat (5) @(negedge clk);
      stray = 1'b0;
      @(posedge clk); #2;
      checki("stray_no_strobe", (rd_cycles - rc0) + (wr_cycles - wc0), 0);
      checki("stray_no_resp", (i_pulses - i0) + (d_pulses - d0), 0);
      for (int k = 0; k < 4; k++) bt[k] = rnd64();
      load(4); snap();
      icache_mem_address = 32'h0000_0880; icache_mem_read = 1'b1;
      serve(40);
      check("stray_after_line", last_i_line, line_of(0));

      // Randomized transactions
      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 3);
         pm_wait = $urandom_range(0, 2);
         for (int k = 0; k < 8; k++) bt[k] = rnd64();
         load(8); snap();
         ia = $urandom; da = $urandom;
         wl = {rnd64(), rnd64(), rnd64(), rnd64()};
         case (kind)
            0: begin icache_mem_address = ia; icache_mem_read = 1'b1; end
            1: begin dcache_mem_address = da; dcache_mem_read = 1'b1; end
            2: begin dcache_mem_address = da; dcache_mem_wdata = wl; dcache_mem_write = 1'b1; end
            default: begin
               icache_mem_address = ia; icache_mem_read = 1'b1;
               dcache_mem_address = da; dcache_mem_read = 1'b1;
            end
         endcase
         serve(200);
         case (kind)
            0: begin
               check("rnd_iline", last_i_line, line_of(0));
               checki("rnd_iaddr", int'(addr_arr[a0]), int'(ia & 32'hFFFF_FFE0));
               last_d = 1'b0;
            end
            1: begin
               check("rnd_dline", last_d_line, line_of(0));
               checki("rnd_daddr", int'(addr_arr[a0]), int'(da & 32'hFFFF_FFE0));
               last_d = 1'b1;
            end
            2: begin
               for (int k = 0; k < 4; k++)
                  check("rnd_wbeat", {192'b0, wr_arr[wr_base + k]}, {192'b0, wl[k*64 +: 64]});
               checki("rnd_waddr", int'(addr_arr[a0]), int'(da & 32'hFFFF_FFE0));
               last_d = 1'b1;
            end
            default: begin
               first_d = RR ? !last_d : 1'b1;
               checki("rnd_pair_first", order_arr[ord0], int'(first_d));
               check("rnd_pair_iline", last_i_line, first_d ? line_of(4) : line_of(0));
               check("rnd_pair_dline", last_d_line, first_d ? line_of(0) : line_of(4));
               last_d = !first_d;
            end
         endcase
      end

      checki("global_both_hi", both_hi, 0);
      checki("global_strobe_in_done", strobe_in_done, 0);
      checki("global_addr_moves", addr_moves, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single physical-memory port of mp4.
- Accepts 256-bit cacheline requests from both caches and grants one at a time.
- Converts each granted request into a 4-beat, 64-bit pmem burst.
- Returns the assembled line and a one-cycle resp to the requesting cache.

Parameters:
- ADDR_WIDTH, 32, byte address width on every port.
- LINE_WIDTH, 256, cacheline width in bits.
- BEAT_WIDTH, 64, pmem data width per beat. BEATS = LINE_WIDTH/BEAT_WIDTH = 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- icache_mem_read  in  1  I-cache line read request, held until icache_mem_resp.
- icache_mem_address  in  ADDR_WIDTH  I-cache line address.
- icache_mem_rdata  out  LINE_WIDTH  line returned to the I-cache.
- icache_mem_resp  out  1  one-cycle completion pulse to the I-cache.
- dcache_mem_read  in  1  D-cache line read request, held until resp.
- dcache_mem_write  in  1  D-cache line writeback request, held until resp.
- dcache_mem_address  in  ADDR_WIDTH  D-cache line address.
- dcache_mem_wdata  in  LINE_WIDTH  writeback line.
- dcache_mem_rdata  out  LINE_WIDTH  line returned to the D-cache.
- dcache_mem_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  burst read strobe.
- pmem_write  out  1  burst write strobe.
- pmem_address  out  ADDR_WIDTH  line-aligned burst address.
- pmem_wdata  out  BEAT_WIDTH  current write beat.
- pmem_rdata  in  BEAT_WIDTH  current read beat.
- pmem_resp  in  1  one pulse per completed beat.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; beat counter 0; line buffer 0; round-robin pointer pointing to D-cache.
- States: IDLE, I_READ, D_READ, D_WRITE, DONE.
- IDLE:
  - Samples requests each cycle.
  - Grant (fixed priority): dcache_mem_write > dcache_mem_read > icache_mem_read.
  - At grant, latch the address with bits [4:0] forced to 0, latch dcache_mem_wdata if writing, clear the counter, enter the burst state.
- Burst states:
  - Hold pmem_read (I_READ/D_READ) or pmem_write (D_WRITE) at 1, and pmem_address constant, for the whole burst.
  - Each pmem_resp advances the beat counter.
  - Read: beat k is stored into line bits [64k+63:64k] on the cycle pmem_resp is high.
  - Write: pmem_wdata = latched wdata bits [64k+63:64k], where k is the current counter value.
  - The cycle carrying the 4th pmem_resp transitions to DONE; pmem strobes drop in DONE.
- DONE:
  - Exactly one cycle: the granted requester's resp = 1, all others 0.
  - The corresponding rdata output carries the full line that cycle.
  - rdata holds that value until the next read to the same cache completes.
  - Next state is IDLE.
  - The requester drops its request at the same edge, so IDLE never re-grants a completed request.
- Latency: grant edge + 4 pmem beats + 1 DONE cycle. With zero-wait pmem (resp every cycle), resp appears 6 cycles after the request is first seen in IDLE.
- pmem_resp arriving in IDLE or DONE is ignored.
- A request that changes or deasserts mid-burst is not re-sampled; the latched transaction completes.
- dcache_mem_read and dcache_mem_write both high: write is granted. A simulation assertion flags it as illegal.
- Losing requester waits, with no timeout; its resp stays 0.
- rst mid-burst: state returns to IDLE and pmem strobes drop immediately. Any partial line is discarded and no resp is issued.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - When both caches request in IDLE, grant goes to the cache not served last.
  - Pointer updates in DONE.
  - D-cache write still beats D-cache read within the D side.
- Undefined:
  - Fixed priority as above; the pointer is not implemented.

Test Plan:
- I-cache read 0x0000_0060, pmem beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with zero wait -> pmem_read high for 4 cycles at 0x0000_0060; icache_mem_resp pulses once with rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- D-cache write 0x8000_0020, wdata beats A,B,C,D, pmem_resp every 2nd cycle -> pmem_wdata shows A,B,C,D in order; pmem_write held for 8 cycles; dcache_mem_resp pulses once; icache_mem_resp stays 0.
- Unaligned address 0x1234_567F -> pmem_address = 0x1234_5660.
- I-read and D-read asserted together, twice back-to-back:
  - Fixed priority: D, then I.
  - With ARB_ROUND_ROBIN_EN and last-served D: I first, then D.
  - No cycle has both resps high.
- rst pulsed after beat 2 of an I-read -> pmem_read is 0 in the same cycle; no icache_mem_resp. The re-issued request then completes normally with fresh data.
- Stray pmem_resp in IDLE -> no state change, counter stays 0, no resp outputs.
